// File: rtl/rca_add_scheduler.sv
// Round-robin owner of a shared external 16-bit ripple-carry adder: latches the
// winner's operands, holds them for SETTLE cycles, then captures the sum.
module rca_add_scheduler #(
  parameter int SETTLE = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [15:0] A0,
  input  logic [15:0] B0,
  input  logic [15:0] A1,
  input  logic [15:0] B1,
  input  logic        Cin0,
  input  logic        Cin1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Done0,
  output logic        Done1,
  output logic [15:0] Sum,
  output logic        Cout,
  output logic        Busy,
  output logic [15:0] AddA,
  output logic [15:0] AddB,
  output logic        AddCin,
  input  logic [15:0] AddSum,
  input  logic        AddCout
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  generate
    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
      $error("rca_add_scheduler: SETTLE must be within 1..255");
    end
  endgenerate

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_owner;
  logic             grant;
  logic             finish;
  logic             win;

  // A tie goes to whichever requester did not own the adder last.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    finish    = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          grant     = 1'b1;
          win       = pick_winner(Req0, Req1, last_owner);
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      Busy       <= 1'b0;
      Gnt0       <= 1'b0;
      Gnt1       <= 1'b0;
      Done0      <= 1'b0;
      Done1      <= 1'b0;
    end else begin
      Gnt0  <= grant & ~win;
      Gnt1  <= grant & win;
      Done0 <= finish & ~owner;
      Done1 <= finish & owner;
      if (grant) begin
        owner <= win;
        cnt   <= CNT_LOAD;
        Busy  <= 1'b1;
      end else if (finish) begin
        last_owner <= owner;
        Busy       <= 1'b0;
      end else if (state == HOLD) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Adder inputs change only on a grant; the result only at the end of the window.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      AddA   <= '0;
      AddB   <= '0;
      AddCin <= 1'b0;
      Sum    <= '0;
      Cout   <= 1'b0;
    end else begin
      if (grant) begin
        AddA   <= win ? A1 : A0;
        AddB   <= win ? B1 : B0;
        AddCin <= win ? Cin1 : Cin0;
      end
      if (finish) begin
        Sum  <= AddSum[DATA_W-1:0];
        Cout <= AddCout;
      end
    end
  end

endmodule

// File: tb/tb_rca_add_scheduler.sv
// Bench for rca_add_scheduler: two instances (SETTLE=6 and SETTLE=1) share stimulus,
// each with a slow-settling adder model and a transaction-level reference model.
module tb_rca_add_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        cin0 = 1'b0, cin1 = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 60) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : u
      localparam int S = (gi == 0) ? 6 : 1;
      logic        gnt0, gnt1, done0, done1, busy, cout, add_cin;
      logic [15:0] sum, add_a, add_b;
      logic [15:0] add_sum = '0;
      logic        add_cout = 1'b0;

      rca_add_scheduler #(.SETTLE(S)) dut (
        .Clk(clk), .Reset(rst), .Req0(req0), .Req1(req1),
        .A0(a0), .B0(b0), .A1(a1), .B1(b1), .Cin0(cin0), .Cin1(cin1),
        .Gnt0(gnt0), .Gnt1(gnt1), .Done0(done0), .Done1(done1),
        .Sum(sum), .Cout(cout), .Busy(busy),
        .AddA(add_a), .AddB(add_b), .AddCin(add_cin),
        .AddSum(add_sum), .AddCout(add_cout)
      );

      // Adder whose output is garbage until its inputs have been stable long enough.
      initial begin : adder
        logic [32:0] prev;
        logic [16:0] r;
        int stab;
        prev = '0;
        stab = 0;
        forever begin
          @(negedge clk);
          if ({add_a, add_b, add_cin} === prev) begin
            if (stab < 1000) stab++;
          end else begin
            stab = 0;
          end
          prev = {add_a, add_b, add_cin};
          r = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
          if (stab < S - 1) begin
            add_sum  = r[15:0] ^ 16'h5A5A;
            add_cout = ~r[16];
          end else begin
            add_sum  = r[15:0];
            add_cout = r[16];
          end
        end
      end

      // Transaction-level model: a grant starts a job finishing S edges later.
      initial begin : model
        bit          m_free, m_last, m_owner, w;
        int          m_rem;
        logic [16:0] m_res;
        logic        e_g0, e_g1, e_d0, e_d1, e_busy, e_cout, e_cin;
        logic [15:0] e_sum, e_a, e_b;
        m_free = 1; m_last = 1; m_owner = 0; m_rem = 0; m_res = '0;
        forever begin
          @(negedge clk);
          if (rst) begin
            m_free = 1; m_last = 1; m_rem = 0;
            e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_busy = 0;
            e_sum = '0; e_cout = 0; e_a = '0; e_b = '0; e_cin = 0;
          end else begin
            e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0;
            if (m_free) begin
              if (req0 || req1) begin
                w = (req0 && req1) ? ~m_last : req1;
                e_a   = w ? a1 : a0;
                e_b   = w ? b1 : b0;
                e_cin = w ? cin1 : cin0;
                m_res = {1'b0, e_a} + {1'b0, e_b} + {16'b0, e_cin};
                if (w) e_g1 = 1; else e_g0 = 1;
                m_owner = w; m_rem = S; m_free = 0; e_busy = 1;
              end
            end else begin
              m_rem--;
              if (m_rem == 0) begin
                e_sum = m_res[15:0]; e_cout = m_res[16];
                if (m_owner) e_d1 = 1; else e_d0 = 1;
                m_last = m_owner; e_busy = 0; m_free = 1;
              end
            end
          end
          chk($sformatf("s%0d_ctl", S), {gnt0, gnt1, done0, done1, busy},
              {e_g0, e_g1, e_d0, e_d1, e_busy});
          chk($sformatf("s%0d_ops", S), {add_a, add_b, add_cin}, {e_a, e_b, e_cin});
          chk($sformatf("s%0d_res", S), {sum, cout}, {e_sum, e_cout});
        end
      end
    end
  endgenerate

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return u[0].gnt0;
      1: return u[0].gnt1;
      2: return u[0].done0;
      3: return u[0].done1;
      4: return u[0].gnt0 | u[0].gnt1;
      5: return u[0].done0 | u[0].done1;
      6: return u[1].gnt0;
      default: return 1'b0;
    endcase
  endfunction

  // Returns the number of cycles until the selected pulse, or -1 on timeout.
  task automatic wait_for(input int sel, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit && n < 0; i++) begin
      step(1);
      if (sig(sel)) n = i;
    end
  endtask

  initial begin
    int n, c0, c1;
    logic w;

    step(2);
    rst = 1'b0;
    step(2);

    // Single request
    req0 = 1; a0 = 16'hA51B; b0 = 16'h52BB; cin0 = 0;
    wait_for(0, 5, n);
    chk("t1_gnt_lat", n, 1);
    req0 = 0;
    wait_for(2, 20, n);
    chk("t1_done_lat", n, 6);
    chk("t1_sum", {u[0].sum, u[0].cout}, {16'hF7D6, 1'b0});

    // Simultaneous requests straight out of reset
    rst = 1; step(1); rst = 0; step(1);
    req0 = 1; a0 = 16'hFFFF; b0 = 16'hFFFF; cin0 = 0;
    req1 = 1; a1 = 16'h5555; b1 = 16'hAAAA; cin1 = 1;
    step(1);
    chk("t2_first", {u[0].gnt0, u[0].gnt1}, 2'b10);
    req0 = 0;
    wait_for(2, 20, n);
    chk("t2_done0", n, 6);
    chk("t2_sum0", {u[0].sum, u[0].cout}, {16'hFFFE, 1'b1});
    step(1);
    chk("t2_gnt1", u[0].gnt1, 1);
    req1 = 0;
    wait_for(3, 20, n);
    chk("t2_done1", n, 6);
    chk("t2_sum1", {u[0].sum, u[0].cout}, {16'h0000, 1'b1});

    // Fairness with both requests held
    req0 = 1; req1 = 1;
    for (int t = 0; t < 6; t++) begin
      wait_for(4, 20, n);
      chk("t3_gnt_seen", n > 0, 1);
      w = u[0].gnt1;
      chk("t3_order", w, t % 2);
      a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
      wait_for(5, 20, n);
      chk("t3_done_who", u[0].done1, w);
    end
    req0 = 0; req1 = 0;
    step(2);

    // Reset in the middle of a transaction
    req1 = 1;
    wait_for(1, 5, n);
    chk("t4_gnt1", n, 1);
    req1 = 0;
    step(2);
    rst = 1;
    step(1);
    chk("t4_rst_ctl", {u[0].gnt0, u[0].gnt1, u[0].done0, u[0].done1, u[0].busy}, 5'b0);
    chk("t4_rst_ops", {u[0].add_a, u[0].add_b, u[0].add_cin}, 33'b0);
    chk("t4_rst_res", {u[0].sum, u[0].cout}, 17'b0);
    rst = 0;
    c1 = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (u[0].done1) c1++;
    end
    chk("t4_no_done1", c1, 0);
    req1 = 1; a1 = 16'h1234; b1 = 16'h4321; cin1 = 0;
    wait_for(1, 5, n);
    chk("t4_regnt", n, 1);
    req1 = 0;
    wait_for(3, 20, n);
    chk("t4_redone", n, 6);
    chk("t4_resum", {u[0].sum, u[0].cout}, {16'h5555, 1'b0});
    step(3);

    // SETTLE=1 back-to-back on requester 0, operands churning after each grant
    req0 = 1; a0 = 16'($urandom);
    wait_for(6, 5, n);
    chk("t5_first", n, 1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 20; i++) begin
      a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
      step(1);
      if (u[1].gnt0) c0++;
      if (u[1].done0) c1++;
    end
    chk("t5_gnts", c0, 10);
    chk("t5_dones", c1, 10);
    req0 = 0;
    step(10);

    // Request raised and dropped while the adder is busy
    req0 = 1;
    wait_for(0, 5, n);
    chk("t6_gnt0", n, 1);
    req0 = 0; req1 = 1;
    step(2);
    chk("t6_busy", u[0].busy, 1);
    req1 = 0;
    c1 = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (u[0].gnt1 || u[0].done1) c1++;
    end
    chk("t6_no_gnt1", c1, 0);

    // Random traffic, occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(299) == 0);
      req0 = ($urandom_range(2) != 0);
      req1 = ($urandom_range(2) != 0);
      a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
      step(1);
    end
    rst = 0; req0 = 0; req1 = 0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_add_scheduler.md
# rca_add_scheduler

Two-requester scheduler that shares one external 16-bit ripple-carry adder (carry-in, 16-bit sum, carry-out). It arbitrates round-robin between requesters, holds the winner's operands on the adder inputs for a programmable settle window, and captures the result into registers. The adder stays purely combinational. This block adds the clocking, ownership and handshake around it.

## Interface
Parameters:
- SETTLE, 6: clock cycles the adder inputs are held before the result is sampled. Legal range 1..255.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req0, Req1  input  1  request from requester 0 / 1; level, held until granted.
- A0, B0, A1, B1  input  16  operands of requester 0 / 1.
- Cin0, Cin1  input  1  carry-in of requester 0 / 1.
- Gnt0, Gnt1  output  1  one-cycle pulse: operands of that requester captured.
- Done0, Done1  output  1  one-cycle pulse: Sum/Cout hold that requester's result.
- Sum  output  16  registered adder sum.
- Cout  output  1  registered adder carry-out.
- Busy  output  1  high while a transaction owns the adder.
- AddA, AddB  output  16  registered operands driven to the adder.
- AddCin  output  1  registered carry-in driven to the adder.
- AddSum  input  16  sum returned by the adder.
- AddCout  input  1  carry-out returned by the adder.

## Operation
- FSM states: IDLE and HOLD. Reset state is IDLE.
- IDLE with no Req: outputs hold and nothing happens.
- IDLE with a Req: pick a winner W.
  - Only one Req high: that requester wins.
  - Both high: the requester that was not the last owner wins.
- On the grant edge:
  - Latch A_W, B_W, Cin_W into AddA, AddB, AddCin.
  - Pulse Gnt_W, set owner to W, load the settle counter with SETTLE-1, set Busy, go to HOLD.
- HOLD, counter > 0: decrement the counter. AddA/AddB/AddCin must not change.
- HOLD, counter == 0:
  - Sample AddSum/AddCout into Sum/Cout and pulse Done_owner.
  - Update the last-owner pointer to the owner, clear Busy, return to IDLE.
- Req0/Req1 are ignored while in HOLD.
- A requester releases Req on seeing its Gnt. If Req is still high in IDLE, it is treated as a new request.
- Dropping Req before it is granted cancels the request with no side effects.
- Operands may change freely after Gnt; only the latched copies are used.
- After Done, AddA/AddB/AddCin and Sum/Cout hold until the next grant / next Done.
- No arithmetic is done inside the block; Sum/Cout are exactly the adder outputs sampled at the end of the window.
- Reset values:
  - Gnt0, Gnt1, Done0, Done1, Busy, Cout, AddCin: 0.
  - Sum, AddA, AddB: 16'h0000.
  - Last-owner pointer: 1, so requester 0 wins the first tie.
- Reset asserted mid-transaction: abort immediately and return to IDLE with reset values. No Done is issued for the aborted transaction.

## Timing
- Edge k: Req_W sampled high in IDLE.
- Cycle after edge k: Gnt_W high, Busy high, AddA/AddB/AddCin valid.
- Edge k+SETTLE: Sum/Cout load. Done_W is high in the following cycle, Busy low in that same cycle.
- Adder inputs are stable for exactly SETTLE cycles before sampling. SETTLE × clock period must exceed the adder's worst-case carry ripple delay.
- Earliest next grant: edge k+SETTLE+1.
- Throughput: one addition per SETTLE+1 cycles.
- Gnt and Done never occur in the same cycle.
- Only one of Gnt0/Gnt1 is ever high; likewise only one of Done0/Done1.

## Test plan
- Single request, SETTLE=6: Req0 with A0=16'hA51B, B0=16'h52BB, Cin0=0.
  - Gnt0 one cycle later.
  - Done0 six cycles after Gnt0, with Sum=16'hF7D6, Cout=0.
  - Gnt1 and Done1 never pulse.
- Simultaneous requests from reset:
  - Req0: 16'hFFFF + 16'hFFFF, Cin0=0.
  - Req1: 16'h5555 + 16'hAAAA, Cin1=1.
  - Required: requester 0 served first (Sum=16'hFFFE, Cout=1), then Gnt1 at the next IDLE edge (Sum=16'h0000, Cout=1).
- Fairness: both Req held continuously for 6 transactions → grants alternate 0,1,0,1,0,1, and each Done pulses the matching requester.
- Mid-transaction reset: Reset pulsed 3 cycles after Gnt1 → all outputs return to reset values immediately, no Done1 appears, and a following Req1 is accepted normally.
- SETTLE=1 with back-to-back Req0 held high: grant every 2 cycles; Done0 in the cycle after each Gnt0; AddA stable from Gnt through Done.
- Late drop: Req1 raised while Busy and dropped before IDLE → no Gnt1, no Done1.
